mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 12 +
 rtl/mem_arbiter_arb_pick.sv | 31 +++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared arbiter constants: FSM state encoding and requester port ids.
package mem_arbiter_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } arb_state_e;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Two-port winner selection; round-robin on ties when ARB_ROUND_ROBIN_EN is
// defined, fixed priority to port 0 otherwise.
module arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic ptr,
   output logic winner
);

`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      if (req0 && req1) begin
         winner = ptr;
      end else if (req1) begin
         winner = PORT1;
      end else begin
         winner = PORT0;
      end
   end
`else
   logic unused_ptr;
   assign unused_ptr = ptr;

   always_comb begin
      winner = (req1 && !req0) ? PORT1 : PORT0;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port async-read memory.
// ARB_ROUND_ROBIN_EN selects round-robin tie-breaking instead of port-0 priority.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       r0_req,
   input  logic       r0_we,
   input  logic [7:0] r0_addr,
   input  logic [7:0] r0_wdata,
   output logic       r0_gnt,
   output logic [7:0] r0_rdata,
   output logic       r0_rvalid,
   input  logic       r1_req,
   input  logic       r1_we,
   input  logic [7:0] r1_addr,
   input  logic [7:0] r1_wdata,
   output logic       r1_gnt,
   output logic [7:0] r1_rdata,
   output logic       r1_rvalid,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_in,
   output logic       mem_write,
   input  logic [7:0] mem_out,
   output logic       busy
);

   arb_state_e state_q, state_d;
   logic       port_q, port_d;
   logic       we_q, we_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       r0_gnt_q, r0_gnt_d, r1_gnt_q, r1_gnt_d;
   logic       r0_rvalid_q, r0_rvalid_d, r1_rvalid_q, r1_rvalid_d;
   logic [7:0] r0_rdata_q, r0_rdata_d, r1_rdata_q, r1_rdata_d;
   logic       winner;
   logic       ptr;

`ifdef ARB_ROUND_ROBIN_EN
   logic ptr_q, ptr_d;
   assign ptr = ptr_q;
`else
   assign ptr = PORT0;
`endif

   arb_pick u_pick (
      .req0   (r0_req),
      .req1   (r1_req),
      .ptr    (ptr),
      .winner (winner)
   );

   always_comb begin
      state_d     = state_q;
      port_d      = port_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      r0_gnt_d    = 1'b0;
      r1_gnt_d    = 1'b0;
      r0_rvalid_d = 1'b0;
      r1_rvalid_d = 1'b0;
      r0_rdata_d  = r0_rdata_q;
      r1_rdata_d  = r1_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_d       = ptr_q;
`endif
      unique case (state_q)
         IDLE: begin
            // gnt is registered on ACCESS entry so it is high exactly during ACCESS
            if (r0_req || r1_req) begin
               state_d  = ACCESS;
               port_d   = winner;
               we_d     = (winner == PORT1) ? r1_we    : r0_we;
               addr_d   = (winner == PORT1) ? r1_addr  : r0_addr;
               wdata_d  = (winner == PORT1) ? r1_wdata : r0_wdata;
               r0_gnt_d = (winner == PORT0);
               r1_gnt_d = (winner == PORT1);
`ifdef ARB_ROUND_ROBIN_EN
               ptr_d    = ~winner;
`endif
            end
         end
         ACCESS: begin
            state_d = IDLE;
            if (!we_q) begin
               if (port_q == PORT0) begin
                  r0_rdata_d  = mem_out;
                  r0_rvalid_d = 1'b1;
               end else begin
                  r1_rdata_d  = mem_out;
                  r1_rvalid_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         port_q      <= PORT0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         r0_gnt_q    <= 1'b0;
         r1_gnt_q    <= 1'b0;
         r0_rvalid_q <= 1'b0;
         r1_rvalid_q <= 1'b0;
         r0_rdata_q  <= '0;
         r1_rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         ptr_q       <= PORT0;
`endif
      end else begin
         state_q     <= state_d;
         port_q      <= port_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         r0_gnt_q    <= r0_gnt_d;
         r1_gnt_q    <= r1_gnt_d;
         r0_rvalid_q <= r0_rvalid_d;
         r1_rvalid_q <= r1_rvalid_d;
         r0_rdata_q  <= r0_rdata_d;
         r1_rdata_q  <= r1_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
         ptr_q       <= ptr_d;
`endif
      end
   end

   assign r0_gnt    = r0_gnt_q;
   assign r1_gnt    = r1_gnt_q;
   assign r0_rvalid = r0_rvalid_q;
   assign r1_rvalid = r1_rvalid_q;
   assign r0_rdata  = r0_rdata_q;
   assign r1_rdata  = r1_rdata_q;
   assign busy      = (state_q == ACCESS);
   assign mem_addr  = addr_q;
   assign mem_in    = wdata_q;
   // rst gates the strobe combinationally so a reset during ACCESS never writes
   assign mem_write = (state_q == ACCESS) && we_q && !rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural async-read memory and a
// grant/read-data scoreboard; honours ARB_ROUND_ROBIN_EN for the tie test.
module tb_mem_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       r0_req, r0_we, r1_req, r1_we;
   logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
   logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
   logic [7:0] r0_rdata, r1_rdata;
   logic [7:0] mem_addr, mem_in, mem_out;
   logic       mem_write, busy;
   logic       preload;

   logic [7:0] mem [256];

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned wr_cnt   = 0;
   logic [7:0]  wr_addr  = '0;

   logic       gnt_q [$];
   logic [8:0] rd_q  [$];

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .r0_req    (r0_req),
      .r0_we     (r0_we),
      .r0_addr   (r0_addr),
      .r0_wdata  (r0_wdata),
      .r0_gnt    (r0_gnt),
      .r0_rdata  (r0_rdata),
      .r0_rvalid (r0_rvalid),
      .r1_req    (r1_req),
      .r1_we     (r1_we),
      .r1_addr   (r1_addr),
      .r1_wdata  (r1_wdata),
      .r1_gnt    (r1_gnt),
      .r1_rdata  (r1_rdata),
      .r1_rvalid (r1_rvalid),
      .mem_addr  (mem_addr),
      .mem_in    (mem_in),
      .mem_write (mem_write),
      .mem_out   (mem_out),
      .busy      (busy)
   );

   assign mem_out = mem[mem_addr];

   always @(posedge clk) begin
      if (preload) begin
         mem[8'h10] <= 8'hA5;
         mem[8'h20] <= 8'h11;
         mem[8'hFF] <= 8'h00;
      end else if (mem_write) begin
         mem[mem_addr] <= mem_in;
      end
   end

   task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Advance to the next falling edge and retire any grant / read data seen there.
   task automatic tick();
      logic [8:0] e;
      logic       p;
      @(negedge clk);
      if (r0_gnt || r1_gnt) begin
         if (gnt_q.size() == 0) begin
            check("unexpected_gnt", {r1_gnt, r0_gnt}, 24'd0);
         end else begin
            p = gnt_q.pop_front();
            check("gnt_port", {r1_gnt, r0_gnt}, p ? 24'd2 : 24'd1);
         end
      end
      if (r0_rvalid || r1_rvalid) begin
         if (rd_q.size() == 0) begin
            check("unexpected_rvalid", {r1_rvalid, r0_rvalid}, 24'd0);
         end else begin
            e = rd_q.pop_front();
            check("rvalid_data", {r1_rvalid, r0_rvalid, (r0_rvalid ? r0_rdata : r1_rdata)},
                  {(e[8] ? 2'b10 : 2'b01), e[7:0]});
         end
      end
      if (mem_write) begin
         wr_cnt++;
         wr_addr = mem_addr;
      end
   endtask

   task automatic do_req(input logic port, input logic we, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] exp_rd);
      if (port == 1'b0) begin
         r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d;
      end else begin
         r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d;
      end
      gnt_q.push_back(port);
      if (!we) rd_q.push_back({port, exp_rd});
   endtask

   initial begin
      int unsigned w0;
      logic        exp_port;

      rst = 1'b1; preload = 1'b1;
      r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
      r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
      tick();
      tick();
      preload = 1'b0;
      check("reset_ctrl", {busy, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_write}, 24'd0);
      check("reset_mem_bus", {mem_addr, mem_in}, 24'd0);
      check("reset_rdata", {r0_rdata, r1_rdata}, 24'd0);
      rst = 1'b0;
      tick();

      // Single read: gnt one cycle after req, data the cycle after that.
      do_req(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
      tick();
      check("rd_gnt_cycle", {r0_gnt, busy, mem_write, mem_addr}, {3'b110, 8'h10});
      r0_req = 1'b0;
      tick();
      check("rd_rvalid_cycle", {r0_rvalid, busy, r0_rdata}, {2'b10, 8'hA5});

      // Write then read back on port 1.
      w0 = wr_cnt;
      do_req(1'b1, 1'b1, 8'hFF, 8'h3C, 8'h00);
      tick();
      check("wr_access", {r1_gnt, mem_write, mem_addr, mem_in}, {2'b11, 8'hFF, 8'h3C});
      r1_req = 1'b0;
      tick();
      check("wr_no_rvalid", {r1_rvalid, mem_write, r1_rdata}, {2'b00, 8'h00});
      do_req(1'b1, 1'b0, 8'hFF, 8'h00, 8'h3C);
      tick();
      check("rd_after_wr_gnt", {r1_gnt, mem_write}, 24'b10);
      r1_req = 1'b0;
      tick();
      check("rd_after_wr_data", {r1_rvalid, r1_rdata}, {1'b1, 8'h3C});
      check("wr_pulse_count", wr_cnt - w0, 24'd1);
      check("wr_pulse_addr", wr_addr, 24'hFF);

      // Contention: both requesters held across four grants.
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h10;
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'hFF;
      for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
         exp_port = (k % 2 == 1);
`else
         exp_port = 1'b0;
`endif
         gnt_q.push_back(exp_port);
         rd_q.push_back({exp_port, (exp_port ? 8'h3C : 8'hA5)});
      end
      for (int k = 0; k < 4; k++) begin
         tick();
`ifdef ARB_ROUND_ROBIN_EN
         check("tie_grant", {r1_gnt, r0_gnt}, (k % 2 == 1) ? 24'd2 : 24'd1);
`else
         check("tie_grant", {r1_gnt, r0_gnt}, 24'd1);
`endif
         if (k == 3) begin
            r0_req = 1'b0;
            r1_req = 1'b0;
         end
         tick();
         check("tie_idle_gap", {busy, r0_gnt, r1_gnt}, 24'd0);
      end

      // Idle hold: nothing moves, last r0 read data retained.
      for (int k = 0; k < 10; k++) begin
         tick();
         check("idle_ctrl", {busy, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_write}, 24'd0);
         check("idle_r0_rdata", r0_rdata, 24'hA5);
      end

      // Reset landing in the ACCESS cycle of a write.
      do_req(1'b0, 1'b1, 8'h20, 8'h77, 8'h00);
      tick();
      check("rstw_access", {r0_gnt, mem_write, mem_addr}, {2'b11, 8'h20});
      rst = 1'b1;
      r0_req = 1'b0;
      #1;
      check("rstw_gated", mem_write, 24'd0);
      tick();
      check("rstw_ctrl", {busy, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_write}, 24'd0);
      check("rstw_bus", {mem_addr, mem_in}, 24'd0);
      check("rstw_rdata", {r0_rdata, r1_rdata}, 24'd0);
      check("rstw_mem_kept", mem[8'h20], 24'h11);
      rst = 1'b0;
      tick();
      check("post_rst_idle", {busy, r0_gnt, r1_gnt, mem_write}, 24'd0);
      check("sb_drained", gnt_q.size() + rd_q.size(), 24'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
